apb_slave_ws: RTL
=================

# apb_slave_ws

Parametrised APB3 slave with programmable wait-state insertion, byte strobes, error response and an on-chip scratch memory. It generalises the existing fixed-timing APB slave in data width, memory depth and response timing. It sits on the simulation DUT's APB bus and is driven by the UVM register-layer integration tests. Timing and error behaviour are configurable at run time through a control register.

## Interface
- DATA_WIDTH, 32: APB data width; must be 32 or 64.
- ADDR_WIDTH, 16: APB byte-address width.
- MEM_SIZE, 128: scratch memory depth in DATA_WIDTH words.
- MEM_BASE, 'h100: byte address of memory word 0; aligned to DATA_WIDTH/8.
- ID_REGISTER, {2'b00,4'h0,10'h176,8'h5A,8'h03}: read-only ID value, zero-extended to DATA_WIDTH.
- WS_RESET, 0: reset value of CTRL.WS (0..15).
- apb_pclk  input  1  clock; all logic is on the rising edge. One clock.
- rst  input  1  synchronous, active-high reset.
- apb_paddr  input  ADDR_WIDTH  byte address.
- apb_psel  input  1  select.
- apb_penable  input  1  access phase.
- apb_pwrite  input  1  1 = write.
- apb_pwdata  input  DATA_WIDTH  write data.
- apb_pstrb  input  DATA_WIDTH/8  write byte strobes.
- apb_prdata  output  DATA_WIDTH  read data; valid when apb_pready=1.
- apb_pready  output  1  transfer completes this cycle.
- apb_pslverr  output  1  error; valid only when apb_pready=1.

## Operation
- Map (offsets in bytes, B = DATA_WIDTH/8):
  - 0x0 ID: read-only.
  - B CTRL: bits [3:0] are WS; other bits read 0.
  - 2B ERR_CNT: 16-bit saturating error count; any write clears it.
  - MEM_BASE .. MEM_BASE+MEM_SIZE*B-1: memory.
- Error (pslverr=1) on:
  - misaligned address (paddr mod B != 0);
  - unmapped address;
  - write to ID.
- An errored transfer changes no state except ERR_CNT+1, which saturates at 0xFFFF.
- A write to ERR_CNT clears it to 0 and is not an error.
- Writes honour pstrb per byte. The ERR_CNT clear ignores pstrb.
- Reads of memory, ID, CTRL and ERR_CNT return full words; errored reads return 0.
- FSM states: IDLE, ACCESS.
  - IDLE: when psel=1 and penable=0 (setup phase), latch the decode result, load wait counter = CTRL.WS, register apb_prdata from the addressed location, then go to ACCESS.
  - ACCESS: counter>0 → decrement, pready=0. Counter==0 → pready=1 and pslverr=latched error; a write commits in this cycle; next state IDLE.
  - ACCESS with psel=0 (protocol violation): abort, no write, no ERR_CNT change, return to IDLE.
- Write to CTRL.WS takes effect from the next transfer.
- Memory contents are not reset. Registers, FSM and outputs are reset.

## Timing
- Reset values:
  - apb_prdata=0, apb_pready=0, apb_pslverr=0;
  - CTRL.WS=WS_RESET, ERR_CNT=0, FSM=IDLE.
- rst asserted mid-transfer: FSM goes to IDLE on that edge, the pending write is dropped, and outputs are 0 from the next cycle.
- Latency is setup + (WS+1) access cycles. WS=0 gives a standard 2-cycle APB transfer with pready high in the first access cycle.
- apb_pready and apb_pslverr are decoded combinationally from FSM state and counter only, with no path from APB inputs. apb_prdata is registered.
- Back-to-back transfers: a new setup may follow in the cycle after pready=1. There is no idle-cycle requirement.
- Memory write and next read of the same word: a read whose setup phase is the cycle after the write's pready returns the new data.

## Structure
- Package apb_slave_ws_pkg holds:
  - state enum;
  - register offset constants and WS field width;
  - a decode-result struct {hit_mem, hit_reg, err, index}.
- One sub-module, apb_slave_ws_mem: MEM_SIZE×DATA_WIDTH array, asynchronous read, byte-strobe synchronous write, no reset.
- Top level contains the FSM, address decode and register bank.

## Test plan
- Reset, then read ID with WS=0 → prdata=ID_REGISTER, pready in the first access cycle, pslverr=0; read CTRL → 0.
- Write CTRL=3, then read MEM_BASE → pready low for 3 access cycles and high on the 4th; total transfer 5 cycles.
- Write 0xDEADBEEF to MEM_BASE+B with pstrb=4'b0101 over prior 0x11223344 → readback 0x11AD33EF.
- Misaligned address (MEM_BASE+1), unmapped address 0x80, and write to ID → each gives pslverr=1 with pready=1; ERR_CNT reads 3; memory and ID unchanged; write ERR_CNT → reads 0.
- With WS=5, assert rst at the 2nd access cycle of a memory write → pready stays 0, word unchanged, CTRL.WS=WS_RESET afterwards.
- With WS=2, drop psel mid-ACCESS on a write → no write, ERR_CNT unchanged; the next transfer completes normally.

Source files
------------

// File: rtl/apb_slave_ws_pkg.sv
// Shared types and constants for the wait-state APB scratch slave.
// Register offsets are word indices; the byte offset is index * DATA_WIDTH/8.
package apb_slave_ws_pkg;

    localparam int WS_W     = 4;
    localparam int IDX_W    = 16;
    localparam int REG_ID   = 0;
    localparam int REG_CTRL = 1;
    localparam int REG_ERR  = 2;
    localparam int NUM_REGS = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic             hit_mem;
        logic             hit_reg;
        logic             err;
        logic [IDX_W-1:0] index;
    } decode_t;

endpackage

// File: rtl/apb_slave_ws_if.sv
// APB3 bus bundle between a single master and the wait-state slave.
// Master drives the request side; the slave returns prdata/pready/pslverr.
interface apb_slave_ws_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_ws_mem.sv
// Scratch word memory: asynchronous read, byte-strobed synchronous write.
// Contents are deliberately not reset.
module apb_slave_ws_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_SIZE   = 128,
    localparam int AW         = $clog2(MEM_SIZE),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NB-1:0]         wstrb
);
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/apb_slave_ws.sv
// APB3 slave: ID/CTRL/ERR_CNT registers plus scratch memory, with CTRL.WS wait states.
// Transfer takes setup + WS+1 access cycles; pready depends only on FSM state and counter.
module apb_slave_ws
    import apb_slave_ws_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 16,
    parameter int          MEM_SIZE    = 128,
    parameter int unsigned MEM_BASE    = 'h100,
    parameter logic [31:0] ID_REGISTER = {2'b00, 4'h0, 10'h176, 8'h5A, 8'h03},
    parameter int          WS_RESET    = 0
) (
    input  logic           apb_pclk,
    input  logic           rst,
    apb_slave_ws_if.slave  apb
);
    localparam int B   = DATA_WIDTH / 8;
    localparam int LSB = $clog2(B);
    localparam int MW  = $clog2(MEM_SIZE);
    localparam logic [31:0] REG_HI = 32'(NUM_REGS * B);
    localparam logic [31:0] MEM_LO = 32'(MEM_BASE);
    localparam logic [31:0] MEM_HI = MEM_LO + 32'(MEM_SIZE * B);
    localparam logic [DATA_WIDTH-1:0] ID_EXT = DATA_WIDTH'(ID_REGISTER);

    state_t                state_q, state_d;
    logic [WS_W-1:0]       ws_q, cnt_q, cnt_d;
    logic [15:0]           err_cnt_q;
    decode_t               dec, dec_q;
    logic                  wr_q;
    logic                  setup, commit, mem_we;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           addr32;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] mem_rdata, rd_val;

    assign paddr = apb.paddr;

    always_comb begin
        addr32      = 32'(paddr);
        misaligned  = (addr32 & 32'(B - 1)) != 32'd0;
        dec         = '0;
        dec.hit_reg = addr32 < REG_HI;
        dec.hit_mem = (addr32 >= MEM_LO) && (addr32 < MEM_HI);
        dec.index   = dec.hit_mem ? IDX_W'((addr32 - MEM_LO) >> LSB) : IDX_W'(addr32 >> LSB);
        dec.err     = misaligned || !(dec.hit_reg || dec.hit_mem) ||
                      (apb.pwrite && dec.hit_reg && dec.index == IDX_W'(REG_ID));
    end

    always_comb begin
        rd_val = '0;
        if (!dec.err) begin
            if (dec.hit_mem)                          rd_val = mem_rdata;
            else if (dec.index == IDX_W'(REG_ID))     rd_val = ID_EXT;
            else if (dec.index == IDX_W'(REG_CTRL))   rd_val = DATA_WIDTH'(ws_q);
            else if (dec.index == IDX_W'(REG_ERR))    rd_val = DATA_WIDTH'(err_cnt_q);
        end
    end

    // Master dropping psel mid-access aborts the transfer without side effects.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        setup       = 1'b0;
        commit      = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    setup   = 1'b1;
                    cnt_d   = ws_q;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                apb.pready  = (cnt_q == '0);
                apb.pslverr = (cnt_q == '0) && dec_q.err;
                if (!apb.psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ws_q       <= WS_W'(WS_RESET);
            err_cnt_q  <= '0;
            dec_q      <= '0;
            wr_q       <= 1'b0;
            apb.prdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                dec_q      <= dec;
                wr_q       <= apb.pwrite;
                apb.prdata <= rd_val;
            end
            if (commit) begin
                if (dec_q.err) begin
                    if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
                end else if (wr_q && dec_q.hit_reg) begin
                    if (dec_q.index == IDX_W'(REG_CTRL) && apb.pstrb[0])
                        ws_q <= apb.pwdata[WS_W-1:0];
                    if (dec_q.index == IDX_W'(REG_ERR))
                        err_cnt_q <= '0;
                end
            end
        end
    end

    assign mem_we = commit && !rst && wr_q && !dec_q.err && dec_q.hit_mem;

    apb_slave_ws_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_mem (
        .clk   (apb_pclk),
        .raddr (dec.index[MW-1:0]),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (dec_q.index[MW-1:0]),
        .wdata (apb.pwdata),
        .wstrb (apb.pstrb)
    );
endmodule
